// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection,
// bubble insertion on stall or flush, and a saturating stall counter.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic              RegDst_i,
    input  logic              ALUSrc_i,
    input  logic              RegWrite_i,
    input  logic              MemRead_i,
    input  logic              MemtoReg_i,
    input  logic              MemWrite_i,
    input  logic [1:0]        ALUOp_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [REG_W-1:0]  rs_addr_i,
    input  logic [REG_W-1:0]  rt_addr_i,
    input  logic [REG_W-1:0]  rd_addr_i,
    output logic              stall_o,
    output logic              RegDst_o,
    output logic              ALUSrc_o,
    output logic              RegWrite_o,
    output logic              MemRead_o,
    output logic              MemtoReg_o,
    output logic              MemWrite_o,
    output logic [1:0]        ALUOp_o,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [REG_W-1:0]  rs_addr_o,
    output logic [REG_W-1:0]  rt_addr_o,
    output logic [REG_W-1:0]  rd_addr_o,
    output logic              ex_valid_o,
    output logic [CNT_W-1:0]  stall_count_o
);

    logic rt_hit;
    logic bubble;
    logic cnt_inc;

    // $0 never carries a loaded value, so it can never cause a hazard
    assign rt_hit = (rt_addr_o != '0) &&
                    ((rt_addr_o == rs_addr_i) ||
                     (rt_addr_o == rt_addr_i));

    assign stall_o = id_valid_i & ex_valid_o & MemRead_o & rt_hit;
    assign bubble  = flush_i | stall_o;
    assign cnt_inc = stall_o & ~flush_i &
                     (stall_count_o != {CNT_W{1'b1}});

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            RegDst_o      <= 1'b0;
            ALUSrc_o      <= 1'b0;
            RegWrite_o    <= 1'b0;
            MemRead_o     <= 1'b0;
            MemtoReg_o    <= 1'b0;
            MemWrite_o    <= 1'b0;
            ALUOp_o       <= 2'b00;
            ex_valid_o    <= 1'b0;
            rs_data_o     <= '0;
            rt_data_o     <= '0;
            imm_o         <= '0;
            rs_addr_o     <= '0;
            rt_addr_o     <= '0;
            rd_addr_o     <= '0;
            stall_count_o <= '0;
        end else begin
            rs_data_o <= rs_data_i;
            rt_data_o <= rt_data_i;
            imm_o     <= imm_i;
            rs_addr_o <= rs_addr_i;
            rt_addr_o <= rt_addr_i;
            rd_addr_o <= rd_addr_i;
            if (bubble) begin
                RegDst_o   <= 1'b0;
                ALUSrc_o   <= 1'b0;
                RegWrite_o <= 1'b0;
                MemRead_o  <= 1'b0;
                MemtoReg_o <= 1'b0;
                MemWrite_o <= 1'b0;
                ALUOp_o    <= 2'b00;
                ex_valid_o <= 1'b0;
            end else begin
                RegDst_o   <= RegDst_i;
                ALUSrc_o   <= ALUSrc_i;
                RegWrite_o <= RegWrite_i;
                MemRead_o  <= MemRead_i;
                MemtoReg_o <= MemtoReg_i;
                MemWrite_o <= MemWrite_i;
                ALUOp_o    <= ALUOp_i;
                ex_valid_o <= id_valid_i;
            end
            if (cnt_inc)
                stall_count_o <= stall_count_o + 1'b1;
        end
    end

endmodule
